// File: rtl/project_onto_camera_if.sv
// Operand and result bus for project_onto_camera.
//   data_in        : operand-valid strobe
//   camera_origin  : camera position, signed Q6.12, [2]=x [1]=y [0]=z
//   point          : world point, signed Q6.12
//   u_vec/v_vec/n_vec : camera right/up/view axes, signed Q6.12
//   u, v           : screen coordinates, signed integer pixels
//   n              : depth along n_vec, signed Q6.12
//   data_out       : one-cycle result-valid pulse
// master drives operands and reads results; slave is the projection core.
interface project_onto_camera_if;
  logic              data_in;
  logic [2:0][17:0]  camera_origin;
  logic [2:0][17:0]  point;
  logic [2:0][17:0]  u_vec;
  logic [2:0][17:0]  v_vec;
  logic [2:0][17:0]  n_vec;
  logic [17:0]       u;
  logic [17:0]       v;
  logic [17:0]       n;
  logic              data_out;

  modport master (
    output data_in, camera_origin, point, u_vec, v_vec, n_vec,
    input  u, v, n, data_out
  );

  modport slave (
    input  data_in, camera_origin, point, u_vec, v_vec, n_vec,
    output u, v, n, data_out
  );
endinterface

// File: rtl/project_onto_camera.sv
// project_onto_camera: perspective projection of a world point onto a camera
// screen. Fully pipelined, one operand set per cycle, fixed 9-cycle latency.
//   clock : rising-edge clock
//   reset : synchronous active-high reset (clears valid bits and outputs)
//   bus   : project_onto_camera_if.slave (operands in, u/v/n/data_out out)
// Pipeline: 1 difference, 2 products, 3 dot sums, 4 sign/magnitude prep,
// 5..9 restoring divider (6 quotient bits per stage), output register.
// Optional macro PROJECT_ONTO_CAMERA_CLIP_EN: suppresses the result pulse
// (and output update) for points with depth dn <= 0.
module project_onto_camera #(
  parameter int SCREEN_CX   = 320,
  parameter int SCREEN_CY   = 240,
  parameter int SCALE_SHIFT = 9
) (
  input  logic                 clock,
  input  logic                 reset,
  project_onto_camera_if.slave bus
);

  localparam int unsigned W        = 18;
  localparam int unsigned FRAC     = 12;
  localparam int unsigned PW       = 2 * W;
  localparam int unsigned NUM_W    = W + FRAC;
  localparam int unsigned ST_W     = W + NUM_W;
  localparam int unsigned Q_MAX    = (1 << (W - 1)) - 1;
  localparam int          DIV_STG  = 5;
  localparam int          DIV_BITS = 6;
  localparam int          PIPE     = 4 + DIV_STG;
  localparam int          PIX_SH   = 12 - SCALE_SHIFT;

  // Q6.12 x Q6.12 product, keeping bits [29:12] of the full 36-bit result.
  function automatic logic [W-1:0] qmul(input logic [W-1:0] a, input logic [W-1:0] b);
    logic signed [PW-1:0] p;
    p = PW'($signed(a)) * PW'($signed(b));
    return W'(p >>> FRAC);
  endfunction

  // |x << 12| as an unsigned 30-bit dividend magnitude.
  function automatic logic [NUM_W-1:0] mag_scaled(input logic [W-1:0] x);
    logic [NUM_W-1:0] t;
    t = {x, {FRAC{1'b0}}};
    return t[NUM_W-1] ? -t : t;
  endfunction

  // DIV_BITS restoring-division steps; state is {remainder, dividend/quotient}
  // where quotient bits shift in as dividend bits shift out.
  function automatic logic [ST_W-1:0] div_steps(input logic [ST_W-1:0] st,
                                                input logic [W-1:0]    den);
    logic [W-1:0]     rem;
    logic [NUM_W-1:0] nq;
    logic [W:0]       trial;
    rem = st[ST_W-1:NUM_W];
    nq  = st[NUM_W-1:0];
    for (int b = 0; b < DIV_BITS; b++) begin
      trial = {rem, nq[NUM_W-1]};
      nq    = {nq[NUM_W-2:0], 1'b0};
      if (trial >= {1'b0, den}) begin
        trial = trial - {1'b0, den};
        nq[0] = 1'b1;
      end
      rem = trial[W-1:0];
    end
    return {rem, nq};
  endfunction

  // Sign, saturate, scale to pixels and add the screen-centre offset.
  function automatic logic [W-1:0] to_pixel(input logic [ST_W-1:0] st,
                                            input logic            neg,
                                            input logic            zero,
                                            input int              centre);
    logic [NUM_W-1:0] mag;
    logic [W-1:0]     q;
    mag = NUM_W'(st);
    if (zero) begin
      q = '0;
    end else if (!neg) begin
      q = (mag > NUM_W'(Q_MAX)) ? W'(Q_MAX) : W'(mag);
    end else begin
      q = (mag > NUM_W'(Q_MAX + 1)) ? W'(Q_MAX + 1) : -W'(mag);
    end
    return W'(centre) + W'($signed(q) >>> PIX_SH);
  endfunction

  // Valid shift register; data_in during reset is dropped.
  logic [PIPE-1:0] vld;

  always_ff @(posedge clock) begin
    if (reset) vld <= '0;
    else       vld <= {vld[PIPE-2:0], bus.data_in};
  end

  // Stage 1: point - origin, axes captured.
  logic [2:0][W-1:0] s1_d, s1_u, s1_v, s1_n;

  always_ff @(posedge clock) begin
    if (bus.data_in) begin
      for (int i = 0; i < 3; i++) s1_d[i] <= bus.point[i] - bus.camera_origin[i];
      s1_u <= bus.u_vec;
      s1_v <= bus.v_vec;
      s1_n <= bus.n_vec;
    end
  end

  // Stage 2: nine fixed-point products.
  logic [2:0][W-1:0] s2_tu, s2_tv, s2_tn;

  always_ff @(posedge clock) begin
    for (int i = 0; i < 3; i++) begin
      s2_tu[i] <= qmul(s1_d[i], s1_u[i]);
      s2_tv[i] <= qmul(s1_d[i], s1_v[i]);
      s2_tn[i] <= qmul(s1_d[i], s1_n[i]);
    end
  end

  // Stage 3: dot products, modulo 2^18.
  logic [W-1:0] s3_du, s3_dv, s3_dn;

  always_ff @(posedge clock) begin
    s3_du <= s2_tu[0] + s2_tu[1] + s2_tu[2];
    s3_dv <= s2_tv[0] + s2_tv[1] + s2_tv[2];
    s3_dn <= s2_tn[0] + s2_tn[1] + s2_tn[2];
  end

  // Stage 4: divide in sign/magnitude so truncation is toward zero.
  logic [NUM_W-1:0] p4_nu, p4_nv;
  logic [W-1:0]     p4_den, p4_dn;
  logic             p4_neg_u, p4_neg_v;

  always_ff @(posedge clock) begin
    p4_nu    <= mag_scaled(s3_du);
    p4_nv    <= mag_scaled(s3_dv);
    p4_den   <= s3_dn[W-1] ? -s3_dn : s3_dn;
    p4_dn    <= s3_dn;
    p4_neg_u <= s3_du[W-1] ^ s3_dn[W-1];
    p4_neg_v <= s3_dv[W-1] ^ s3_dn[W-1];
  end

  // Stages 5..9: pipelined restoring divider shared divisor for u and v.
  logic [ST_W-1:0] st_u    [DIV_STG];
  logic [ST_W-1:0] st_v    [DIV_STG];
  logic [W-1:0]    den_q   [DIV_STG];
  logic [W-1:0]    dn_q    [DIV_STG];
  logic            neg_u_q [DIV_STG];
  logic            neg_v_q [DIV_STG];

  always_ff @(posedge clock) begin
    st_u[0]    <= div_steps({W'(0), p4_nu}, p4_den);
    st_v[0]    <= div_steps({W'(0), p4_nv}, p4_den);
    den_q[0]   <= p4_den;
    dn_q[0]    <= p4_dn;
    neg_u_q[0] <= p4_neg_u;
    neg_v_q[0] <= p4_neg_v;
    for (int s = 1; s < DIV_STG; s++) begin
      st_u[s]    <= div_steps(st_u[s-1], den_q[s-1]);
      st_v[s]    <= div_steps(st_v[s-1], den_q[s-1]);
      den_q[s]   <= den_q[s-1];
      dn_q[s]    <= dn_q[s-1];
      neg_u_q[s] <= neg_u_q[s-1];
      neg_v_q[s] <= neg_v_q[s-1];
    end
  end

  // Output stage: results update only when a pulse is emitted.
  logic dn_zero_c;
  logic emit_c;

  assign dn_zero_c = (den_q[DIV_STG-1] == '0);

`ifdef PROJECT_ONTO_CAMERA_CLIP_EN
  assign emit_c = vld[PIPE-1] && !dn_q[DIV_STG-1][W-1] && !dn_zero_c;
`else
  assign emit_c = vld[PIPE-1];
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      bus.data_out <= 1'b0;
      bus.u        <= '0;
      bus.v        <= '0;
      bus.n        <= '0;
    end else begin
      bus.data_out <= emit_c;
      if (emit_c) begin
        bus.u <= to_pixel(st_u[DIV_STG-1], neg_u_q[DIV_STG-1], dn_zero_c, SCREEN_CX);
        bus.v <= to_pixel(st_v[DIV_STG-1], neg_v_q[DIV_STG-1], dn_zero_c, SCREEN_CY);
        bus.n <= dn_q[DIV_STG-1];
      end
    end
  end

endmodule

// File: tb/tb_project_onto_camera.sv
// Self-checking bench for project_onto_camera: directed literal cases plus
// randomized traffic compared every cycle against a transaction-level model.
module tb_project_onto_camera;

  localparam int SCREEN_CX   = 320;
  localparam int SCREEN_CY   = 240;
  localparam int SCALE_SHIFT = 9;
  localparam int LAT         = 9;
  localparam int PIX_SH      = 12 - SCALE_SHIFT;

`ifdef PROJECT_ONTO_CAMERA_CLIP_EN
  localparam bit CLIP = 1'b1;
`else
  localparam bit CLIP = 1'b0;
`endif

  typedef struct packed {
    logic [2:0][17:0] o;
    logic [2:0][17:0] p;
    logic [2:0][17:0] a;
    logic [2:0][17:0] b;
    logic [2:0][17:0] c;
  } ops_t;

  typedef struct {
    logic [17:0] u;
    logic [17:0] v;
    logic [17:0] n;
    bit          emit;
    int          due;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;

  project_onto_camera_if bus();

  project_onto_camera #(
    .SCREEN_CX  (SCREEN_CX),
    .SCREEN_CY  (SCREEN_CY),
    .SCALE_SHIFT(SCALE_SHIFT)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  int   vectors     = 0;
  int   miscompares = 0;
  int   edge_n      = 0;
  bit   model_ok    = 1'b0;
  exp_t pipe[$];
  logic [17:0] mu = '0, mv = '0, mn = '0;
  logic        mdo = 1'b0;

  function automatic longint sx18(input logic [17:0] x);
    return longint'($signed(x));
  endfunction

  function automatic longint wrap18(input longint x);
    logic [17:0] t;
    t = x[17:0];
    return longint'($signed(t));
  endfunction

  function automatic longint sat18(input longint x);
    if (x > 131071)  return 131071;
    if (x < -131072) return -131072;
    return x;
  endfunction

  // Reference projection from plain integer arithmetic.
  function automatic exp_t model(input ops_t x);
    exp_t   e;
    longint d, du, dv, dn, qu, qv;
    du = 0; dv = 0; dn = 0;
    for (int i = 0; i < 3; i++) begin
      d  = wrap18(sx18(x.p[i]) - sx18(x.o[i]));
      du = du + wrap18((d * sx18(x.a[i])) >>> 12);
      dv = dv + wrap18((d * sx18(x.b[i])) >>> 12);
      dn = dn + wrap18((d * sx18(x.c[i])) >>> 12);
    end
    du = wrap18(du); dv = wrap18(dv); dn = wrap18(dn);
    if (dn == 0) begin
      qu = 0; qv = 0;
    end else begin
      qu = sat18((du * 4096) / dn);
      qv = sat18((dv * 4096) / dn);
    end
    e.u    = 18'(SCREEN_CX + (qu >>> PIX_SH));
    e.v    = 18'(SCREEN_CY + (qv >>> PIX_SH));
    e.n    = 18'(dn);
    e.emit = CLIP ? (dn > 0) : 1'b1;
    e.due  = 0;
    return e;
  endfunction

  // Model advances on each rising edge from the inputs the DUT samples.
  always @(posedge clock) begin
    exp_t e;
    ops_t cur;
    edge_n = edge_n + 1;
    if (reset) begin
      pipe.delete();
      mu = '0; mv = '0; mn = '0; mdo = 1'b0;
    end else begin
      mdo = 1'b0;
      if (pipe.size() > 0 && pipe[0].due == edge_n) begin
        e = pipe.pop_front();
        if (e.emit) begin
          mdo = 1'b1; mu = e.u; mv = e.v; mn = e.n;
        end
      end
      if (bus.data_in) begin
        cur.o = bus.camera_origin; cur.p = bus.point;
        cur.a = bus.u_vec; cur.b = bus.v_vec; cur.c = bus.n_vec;
        e     = model(cur);
        e.due = edge_n + LAT;
        pipe.push_back(e);
      end
    end
    model_ok = 1'b1;
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clock) begin
    if (model_ok) begin
      vectors = vectors + 1;
      if ({bus.data_out, bus.u, bus.v, bus.n} !== {mdo, mu, mv, mn}) begin
        miscompares = miscompares + 1;
        $display("FAIL model_cmp edge %0d: got do=%b u=%h v=%h n=%h expected do=%b u=%h v=%h n=%h",
                 edge_n, bus.data_out, bus.u, bus.v, bus.n, mdo, mu, mv, mn);
      end
    end
  end

  task automatic check(input string name, input logic [17:0] got, input logic [17:0] exp);
    vectors = vectors + 1;
    if (got !== exp) begin
      miscompares = miscompares + 1;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic check_out(input string name, input logic edo,
                           input logic [17:0] eu, input logic [17:0] ev, input logic [17:0] en);
    check({name, ".data_out"}, {17'd0, bus.data_out}, {17'd0, edo});
    check({name, ".u"}, bus.u, eu);
    check({name, ".v"}, bus.v, ev);
    check({name, ".n"}, bus.n, en);
  endtask

  task automatic drive(input ops_t x, input logic vld);
    bus.camera_origin = x.o;
    bus.point         = x.p;
    bus.u_vec         = x.a;
    bus.v_vec         = x.b;
    bus.n_vec         = x.c;
    bus.data_in       = vld;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Present one operand set for one sampling edge; returns 1 ns after it.
  task automatic send(input ops_t x);
    drive(x, 1'b1);
    tick();
    bus.data_in = 1'b0;
  endtask

  function automatic logic [17:0] rnd(input int mode);
    int r;
    if (mode == 0) return 18'($urandom);
    r = int'($urandom_range(0, 32767)) - 16384;
    return 18'(r);
  endfunction

  function automatic ops_t rnd_ops();
    ops_t x;
    int   mode;
    mode = int'($urandom_range(0, 3));
    for (int i = 0; i < 3; i++) begin
      x.o[i] = rnd(mode == 0 ? 0 : 1);
      x.p[i] = rnd(mode == 0 ? 0 : 1);
      x.a[i] = rnd(mode == 0 ? 0 : 1);
      x.b[i] = rnd(mode == 0 ? 0 : 1);
      x.c[i] = rnd(mode == 0 ? 0 : 1);
    end
    if (mode == 2) x.p = x.o;
    if (mode == 3) x.c = '0;
    return x;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, edge %0d", edge_n);
    $fatal(1, "timeout");
  end

  initial begin
    ops_t a_ops, b_ops, z_ops, bh_ops, idle;
    idle = '0;

    a_ops.o = '0;
    a_ops.p = {18'h00000, 18'h01000, 18'h3E000};
    a_ops.a = {18'h00B50, 18'h00B50, 18'h00000};
    a_ops.b = {18'h3F4B0, 18'h00B50, 18'h00000};
    a_ops.c = {18'h00000, 18'h00000, 18'h3F000};
    b_ops   = a_ops;
    b_ops.p = {18'h01000, 18'h01000, 18'h3D000};
    z_ops   = a_ops;
    z_ops.p = '0;
    bh_ops   = a_ops;
    bh_ops.p = {18'h00000, 18'h00000, 18'h02000};

    drive(idle, 1'b0);
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    check_out("reset_state", 1'b0, 18'd0, 18'd0, 18'd0);

    // Single input A: exact 9-cycle latency.
    send(a_ops);
    repeat (LAT - 1) tick();
    check("a_early.data_out", {17'd0, bus.data_out}, 18'd0);
    tick();
    check_out("a_result", 1'b1, 18'd501, 18'd421, 18'h02000);
    tick();
    check_out("a_hold", 1'b0, 18'd501, 18'd421, 18'h02000);

    // Single input B.
    send(b_ops);
    repeat (LAT - 1) tick();
    tick();
    check_out("b_result", 1'b1, 18'd561, 18'd240, 18'h03000);

    // Back-to-back A then B.
    drive(a_ops, 1'b1);
    tick();
    drive(b_ops, 1'b1);
    tick();
    drive(idle, 1'b0);
    repeat (LAT - 2) tick();
    check("b2b_early.data_out", {17'd0, bus.data_out}, 18'd0);
    tick();
    check_out("b2b_first", 1'b1, 18'd501, 18'd421, 18'h02000);
    tick();
    check_out("b2b_second", 1'b1, 18'd561, 18'd240, 18'h03000);
    tick();
    check_out("b2b_after", 1'b0, 18'd561, 18'd240, 18'h03000);

    // Reset four cycles after an input discards it.
    send(a_ops);
    repeat (3) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < LAT + 2; i++) begin
      tick();
      check_out("flush", 1'b0, 18'd0, 18'd0, 18'd0);
    end

    // Prime outputs, then dn == 0 and a point behind the camera.
    send(a_ops);
    repeat (LAT) tick();
    check_out("prime", 1'b1, 18'd501, 18'd421, 18'h02000);
    send(z_ops);
    repeat (LAT) tick();
    if (CLIP) check_out("dn_zero", 1'b0, 18'd501, 18'd421, 18'h02000);
    else      check_out("dn_zero", 1'b1, 18'd320, 18'd240, 18'h00000);
    send(bh_ops);
    repeat (LAT) tick();
    if (CLIP) check_out("behind", 1'b0, 18'd501, 18'd421, 18'h02000);
    else      check_out("behind", 1'b1, 18'd320, 18'd240, 18'h3E000);

    // Randomized traffic; operands change every cycle regardless of data_in.
    for (int i = 0; i < 3000; i++) begin
      drive(rnd_ops(), ($urandom_range(0, 3) != 0));
      reset = ($urandom_range(0, 299) == 0);
      tick();
    end
    reset = 1'b0;
    drive(rnd_ops(), 1'b0);
    repeat (LAT + 3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
